// File: rtl/tmp100_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tmp100_pkg
// Shared definitions for the TMP100 polling controller.
//   - tmp100_state_t : controller FSM states
//   - TMP100 register pointers, configuration byte and I2C engine group numbers
//   - temperature LSB scale (documentation constant)
// No ports; imported by tmp100_poll_ctrl and tmp100_avg4.
// -----------------------------------------------------------------------------
package tmp100_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP    = 3'd0,
    ST_CFG_GO   = 3'd1,
    ST_CFG_WAIT = 3'd2,
    ST_IDLE     = 3'd3,
    ST_RD_GO    = 3'd4,
    ST_RD_WAIT  = 3'd5
  } tmp100_state_t;

  // TMP100 pointer register values
  localparam logic [7:0] PTR_TEMP = 8'h00;
  localparam logic [7:0] PTR_CFG  = 8'h01;

  // Configuration byte: R1:R0 = 11 -> 12-bit conversion resolution
  localparam logic [7:0] CFG_DATA = 8'h60;

  // I2C engine operation groups
  localparam logic [7:0] GRP_CFG  = 8'd4;  // write CFG_DATA to PTR_CFG, then pointer back to PTR_TEMP
  localparam logic [7:0] GRP_RD   = 8'd2;  // 2-byte read of the temperature register

  // Temperature scale: one LSB of the 12-bit result is 0.0625 C (625e-4 C)
  localparam int unsigned TEMP_LSB_E4C = 625;

  // The engine samples its start strobe at half rate, so hold it for 4 cycles
  localparam logic [15:0] STAT_CYC = 16'd4;

endpackage

// File: rtl/tmp100_avg4.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tmp100_avg4
// Keeps the last four temperature samples, produces their mean and a
// hysteretic over-temperature flag.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   sample_en        : a new sample is present on sample_in this cycle
//   sample_in [11:0] : signed sample, 0.0625 C/LSB
//   temp_raw  [11:0] : last sample (updates on the edge that takes sample_en)
//   temp_avg  [11:0] : floor of the mean of the 4-entry history (same edge)
//   temp_valid       : one-cycle pulse the cycle after temp_raw/temp_avg update
//   over_temp        : set at avg >= T_HI, cleared at avg <= T_LO
// -----------------------------------------------------------------------------
module tmp100_avg4
  import tmp100_pkg::*;
#(
  parameter logic signed [11:0] T_HI = 12'sd1120,
  parameter logic signed [11:0] T_LO = 12'sd1040
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_en,
  input  logic [11:0] sample_in,
  output logic [11:0] temp_raw,
  output logic [11:0] temp_avg,
  output logic        temp_valid,
  output logic        over_temp
);

  logic [11:0] hist_q [4];
  logic [11:0] hist_d [4];
  logic        have_q, have_d;
  logic [11:0] raw_q, raw_d;
  logic [11:0] avg_q, avg_d;
  logic        pend_q, pend_d;
  logic        valid_q, valid_d;
  logic        over_q, over_d;
  logic signed [13:0] sum_d;

  // History shift. The very first sample fills every entry so the mean is
  // meaningful immediately; later samples push the oldest entry out.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_hist
      if (gi == 0) begin : g_head
        assign hist_d[gi] = sample_en ? sample_in : hist_q[gi];
      end else begin : g_tail
        assign hist_d[gi] = !sample_en ? hist_q[gi] :
                            (have_q ? hist_q[gi-1] : sample_in);
      end
    end
  endgenerate

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < 4; i++) begin
      sum_d = sum_d + $signed({{2{hist_d[i][11]}}, hist_d[i]});
    end
  end

  always_comb begin
    have_d  = have_q | sample_en;
    raw_d   = sample_en ? sample_in : raw_q;
    // Dropping the two LSBs of the two's-complement sum is an arithmetic
    // shift right by 2, i.e. division by 4 rounding toward minus infinity.
    avg_d   = sample_en ? sum_d[13:2] : avg_q;
    pend_d  = sample_en;
    valid_d = pend_q;
    over_d  = over_q;
    // Compare the freshly registered mean; flag updates with temp_valid.
    if (pend_q) begin
      if ($signed(avg_q) >= T_HI) begin
        over_d = 1'b1;
      end else if ($signed(avg_q) <= T_LO) begin
        over_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        hist_q[i] <= '0;
      end
      have_q  <= 1'b0;
      raw_q   <= '0;
      avg_q   <= '0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        hist_q[i] <= hist_d[i];
      end
      have_q  <= have_d;
      raw_q   <= raw_d;
      avg_q   <= avg_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      over_q  <= over_d;
    end
  end

  assign temp_raw   = raw_q;
  assign temp_avg   = avg_q;
  assign temp_valid = valid_q;
  assign over_temp  = over_q;

endmodule

// File: rtl/tmp100_poll_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tmp100_poll_ctrl
// Drives an I2C engine to configure a TMP100 for 12-bit conversions after
// power-up, then reads its temperature every POLL_DIV cycles.
// Ports:
//   i2c_clk_in, i2c_rst_in : clock, asynchronous active-high reset
//   poll_en                : periodic reads enabled while high
//   i2c_wr_rd, group_number: engine operation select (held through the wait)
//   i2c_stat               : engine start strobe (4 cycles)
//   i2c_wend               : engine end-of-write pulse
//   i2c_reg_out, i2c_rd_valid : engine read data and its valid pulse
//   temp_raw, temp_avg, temp_valid, over_temp : see tmp100_avg4
//   busy                   : transaction outstanding
//   err_cnt                : saturating timeout counter
// Parameters: POLL_DIV (>=2), PWRUP_DLY (>=1), TMO_CYC (>=1), T_HI, T_LO.
// -----------------------------------------------------------------------------
module tmp100_poll_ctrl
  import tmp100_pkg::*;
#(
  parameter logic [31:0]        POLL_DIV  = 32'd400000,
  parameter logic [15:0]        PWRUP_DLY = 16'd1000,
  parameter logic [15:0]        TMO_CYC   = 16'd2000,
  parameter logic signed [11:0] T_HI      = 12'sd1120,
  parameter logic signed [11:0] T_LO      = 12'sd1040
) (
  input  logic        i2c_clk_in,
  input  logic        i2c_rst_in,
  input  logic        poll_en,
  output logic        i2c_wr_rd,
  output logic [7:0]  group_number,
  output logic        i2c_stat,
  input  logic        i2c_wend,
  input  logic [15:0] i2c_reg_out,
  input  logic        i2c_rd_valid,
  output logic [11:0] temp_raw,
  output logic [11:0] temp_avg,
  output logic        temp_valid,
  output logic        over_temp,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  tmp100_state_t state_q, state_d;
  logic [15:0]   tmr_q, tmr_d;        // shared by power-up, strobe and timeout timing
  logic [31:0]   poll_q, poll_d;
  logic          cfg_done_q, cfg_done_d;
  logic          stat_q, stat_d;
  logic          wr_rd_q, wr_rd_d;
  logic [7:0]    grp_q, grp_d;
  logic          busy_q, busy_d;
  logic [7:0]    err_q, err_d;

  logic          poll_hit;
  logic          tmo_hit;
  logic [7:0]    err_inc;
  logic          sample_en;
  logic          unused_lsbs;

  assign poll_hit  = cfg_done_q && (poll_q == POLL_DIV - 32'd1);
  assign tmo_hit   = (tmr_q == TMO_CYC - 16'd1);
  assign err_inc   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
  // Read data is accepted only while a read is actually outstanding.
  assign sample_en = (state_q == ST_RD_WAIT) && i2c_rd_valid;
  // At 12-bit resolution the TMP100 always returns zeros in the low nibble.
  assign unused_lsbs = ^i2c_reg_out[3:0];

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    poll_d     = poll_q;
    cfg_done_d = cfg_done_q;
    stat_d     = stat_q;
    wr_rd_d    = wr_rd_q;
    grp_d      = grp_q;
    busy_d     = busy_q;
    err_d      = err_q;

    // Poll timer free-runs once the device is configured, independent of poll_en.
    if (cfg_done_q) begin
      poll_d = poll_hit ? 32'd0 : poll_q + 32'd1;
    end

    case (state_q)
      ST_PWRUP: begin
        if (tmr_q == PWRUP_DLY - 16'd1) begin
          state_d = ST_CFG_GO;
          tmr_d   = '0;
          stat_d  = 1'b1;
          wr_rd_d = 1'b0;
          grp_d   = GRP_CFG;
          busy_d  = 1'b1;
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end

      ST_CFG_GO, ST_RD_GO: begin
        if (tmr_q == STAT_CYC - 16'd1) begin
          stat_d = 1'b0;
          tmr_d  = '0;
          if (state_q == ST_CFG_GO) begin
            state_d = ST_CFG_WAIT;
          end else begin
            state_d = ST_RD_WAIT;
          end
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end

      ST_CFG_WAIT: begin
        if (i2c_wend) begin
          state_d    = ST_IDLE;
          tmr_d      = '0;
          busy_d     = 1'b0;
          cfg_done_d = 1'b1;
          poll_d     = '0;
        end else if (tmo_hit) begin
          // cfg_done stays low, so IDLE immediately retries the write
          state_d = ST_IDLE;
          tmr_d   = '0;
          busy_d  = 1'b0;
          err_d   = err_inc;
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end

      ST_IDLE: begin
        if (!cfg_done_q) begin
          state_d = ST_CFG_GO;
          tmr_d   = '0;
          stat_d  = 1'b1;
          wr_rd_d = 1'b0;
          grp_d   = GRP_CFG;
          busy_d  = 1'b1;
        end else if (poll_hit && poll_en) begin
          state_d = ST_RD_GO;
          tmr_d   = '0;
          stat_d  = 1'b1;
          wr_rd_d = 1'b1;
          grp_d   = GRP_RD;
          busy_d  = 1'b1;
        end
      end

      ST_RD_WAIT: begin
        // i2c_wend is deliberately ignored here: a read ends on data valid.
        if (i2c_rd_valid) begin
          state_d = ST_IDLE;
          tmr_d   = '0;
          busy_d  = 1'b0;
        end else if (tmo_hit) begin
          state_d = ST_IDLE;
          tmr_d   = '0;
          busy_d  = 1'b0;
          err_d   = err_inc;
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end

      default: begin
        state_d = ST_PWRUP;
        tmr_d   = '0;
        stat_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i2c_clk_in or posedge i2c_rst_in) begin
    if (i2c_rst_in) begin
      state_q    <= ST_PWRUP;
      tmr_q      <= '0;
      poll_q     <= '0;
      cfg_done_q <= 1'b0;
      stat_q     <= 1'b0;
      wr_rd_q    <= 1'b0;
      grp_q      <= '0;
      busy_q     <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      poll_q     <= poll_d;
      cfg_done_q <= cfg_done_d;
      stat_q     <= stat_d;
      wr_rd_q    <= wr_rd_d;
      grp_q      <= grp_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign i2c_stat     = stat_q;
  assign i2c_wr_rd    = wr_rd_q;
  assign group_number = grp_q;
  assign busy         = busy_q;
  assign err_cnt      = err_q;

  tmp100_avg4 #(
    .T_HI (T_HI),
    .T_LO (T_LO)
  ) u_avg4 (
    .clk        (i2c_clk_in),
    .rst        (i2c_rst_in),
    .sample_en  (sample_en),
    .sample_in  (i2c_reg_out[15:4]),
    .temp_raw   (temp_raw),
    .temp_avg   (temp_avg),
    .temp_valid (temp_valid),
    .over_temp  (over_temp)
  );

endmodule

// File: tb/tb_tmp100_poll_ctrl.sv
`timescale 1ns/1ps
// Testbench for tmp100_poll_ctrl with POLL_DIV=100, PWRUP_DLY=10, TMO_CYC=50.
// The main process plays the I2C engine and pushes expected sample results
// into a queue; a monitor pops and compares whenever temp_valid is high.
module tb_tmp100_poll_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        poll_en = 1'b1;
  logic        wend = 1'b0;
  logic        rd_valid = 1'b0;
  logic [15:0] reg_out = 16'h0000;
  logic        i2c_wr_rd;
  logic [7:0]  group_number;
  logic        i2c_stat;
  logic [11:0] temp_raw;
  logic [11:0] temp_avg;
  logic        temp_valid;
  logic        over_temp;
  logic        busy;
  logic [7:0]  err_cnt;

  tmp100_poll_ctrl #(
    .POLL_DIV  (32'd100),
    .PWRUP_DLY (16'd10),
    .TMO_CYC   (16'd50),
    .T_HI      (12'sd1120),
    .T_LO      (12'sd1040)
  ) dut (
    .i2c_clk_in   (clk),
    .i2c_rst_in   (rst),
    .poll_en      (poll_en),
    .i2c_wr_rd    (i2c_wr_rd),
    .group_number (group_number),
    .i2c_stat     (i2c_stat),
    .i2c_wend     (wend),
    .i2c_reg_out  (reg_out),
    .i2c_rd_valid (rd_valid),
    .temp_raw     (temp_raw),
    .temp_avg     (temp_avg),
    .temp_valid   (temp_valid),
    .over_temp    (over_temp),
    .busy         (busy),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [11:0] raw;
    logic [11:0] avg;
    logic        ot;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  typedef struct {
    logic [15:0] r;
    logic [11:0] raw;
    logic [11:0] avg;
    logic        ot;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  // Monitor: one comparison set per temp_valid pulse.
  always @(negedge clk) begin
    if (!rst && temp_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL temp_valid_unexpected: temp_valid=1 raw=0x%0h, expected no pulse", temp_raw);
      end else begin
        mon_e = exp_q.pop_front();
        check("temp_raw", 32'(temp_raw), 32'(mon_e.raw));
        check("temp_avg", 32'(temp_avg), 32'(mon_e.avg));
        check("over_temp", 32'(over_temp), 32'(mon_e.ot));
        check("valid_latency_cyc", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  // Waits for i2c_stat, then checks strobe width and operation select.
  // Returns at the negedge after the strobe fell (DUT in its wait state).
  task automatic wait_stat(input logic exp_wr, input logic [7:0] exp_grp,
                           input int budget, output int waited);
    int w;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!i2c_stat && waited < budget);
    if (!i2c_stat) begin
      n_checks++;
      n_errors++;
      $display("FAIL stat_timeout: no i2c_stat within %0d cycles, expected a start", budget);
      return;
    end
    check("stat_wr_rd_first", 32'(i2c_wr_rd), 32'(exp_wr));
    check("stat_group_first", 32'(group_number), 32'(exp_grp));
    check("stat_busy", 32'(busy), 32'd1);
    w = 0;
    while (i2c_stat && w < 8) begin
      w++;
      @(negedge clk);
    end
    check("stat_width", 32'(w), 32'd4);
    check("wait_wr_rd_held", 32'(i2c_wr_rd), 32'(exp_wr));
    check("wait_group_held", 32'(group_number), 32'(exp_grp));
  endtask

  task automatic eng_wend();
    @(posedge clk); #1 wend = 1'b1;
    @(posedge clk); #1 wend = 1'b0;
  endtask

  // A read answers with a (to-be-ignored) wend, then the data pulse.
  task automatic eng_read(input vec_t v);
    exp_t e;
    eng_wend();
    rd_valid = 1'b1;
    reg_out  = v.r;
    e.raw = v.raw;
    e.avg = v.avg;
    e.ot  = v.ot;
    e.cyc = cyc + 2;
    exp_q.push_back(e);
    @(posedge clk); #1 rd_valid = 1'b0;
    reg_out = 16'h0000;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_idle(input int budget, output int k);
    k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_stat"},  32'(i2c_stat), 32'd0);
    check({tag, "_wr_rd"}, 32'(i2c_wr_rd), 32'd0);
    check({tag, "_group"}, 32'(group_number), 32'd0);
    check({tag, "_raw"},   32'(temp_raw), 32'd0);
    check({tag, "_avg"},   32'(temp_avg), 32'd0);
    check({tag, "_valid"}, 32'(temp_valid), 32'd0);
    check({tag, "_ot"},    32'(over_temp), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_err"},   32'(err_cnt), 32'd0);
  endtask

  function automatic vec_t mk(input logic [15:0] r, input logic [11:0] raw,
                              input logic [11:0] avg, input logic ot);
    vec_t v;
    v.r = r; v.raw = raw; v.avg = avg; v.ot = ot;
    return v;
  endfunction

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int k;
    int seen;
    vec_t v;

    // Hand-computed: avg = floor(sum of 4-entry history / 4), first sample fills all.
    vecs.push_back(mk(16'h1900, 12'h190, 12'h190, 1'b0)); // 400
    vecs.push_back(mk(16'h1900, 12'h190, 12'h190, 1'b0)); // 1600/4
    vecs.push_back(mk(16'h4B00, 12'h4B0, 12'h258, 1'b0)); // 2400/4=600
    vecs.push_back(mk(16'h4B00, 12'h4B0, 12'h320, 1'b0)); // 3200/4=800
    vecs.push_back(mk(16'h4B00, 12'h4B0, 12'h3E8, 1'b0)); // 4000/4=1000
    vecs.push_back(mk(16'h4B00, 12'h4B0, 12'h4B0, 1'b1)); // 1200 >= 1120 sets
    vecs.push_back(mk(16'h3E80, 12'h3E8, 12'h47E, 1'b1)); // 1150
    vecs.push_back(mk(16'h3E80, 12'h3E8, 12'h44C, 1'b1)); // 1100 holds
    vecs.push_back(mk(16'h3E80, 12'h3E8, 12'h41A, 1'b1)); // 1050 holds
    vecs.push_back(mk(16'h3E80, 12'h3E8, 12'h3E8, 1'b0)); // 1000 <= 1040 clears
    vecs.push_back(mk(16'hE700, 12'hE70, 12'h28A, 1'b0)); // (-400+3000)/4=650
    vecs.push_back(mk(16'hE700, 12'hE70, 12'h12C, 1'b0)); // 1200/4=300
    vecs.push_back(mk(16'hE700, 12'hE70, 12'hFCE, 1'b0)); // -200/4=-50
    vecs.push_back(mk(16'hE700, 12'hE70, 12'hE70, 1'b0)); // -400
    vecs.push_back(mk(16'hFFF0, 12'hFFF, 12'hED3, 1'b0)); // floor(-1201/4)=-301
    vecs.push_back(mk(16'h0010, 12'h001, 12'hF38, 1'b0)); // -800/4=-200

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");

    // Released at a negedge: the 10th rising edge raises i2c_stat, first seen
    // at the 10th negedge.
    rst = 1'b0;
    wait_stat(1'b0, 8'd4, 40, w);
    check("pwrup_latency", 32'(w), 32'd10);
    eng_wend();
    @(negedge clk);
    check("cfg_done_busy", 32'(busy), 32'd0);

    // Stray engine pulses while IDLE are ignored
    @(posedge clk); #1 rd_valid = 1'b1; wend = 1'b1; reg_out = 16'h7FF0;
    @(posedge clk); #1 rd_valid = 1'b0; wend = 1'b0; reg_out = 16'h0000;
    repeat (3) @(negedge clk);
    check("stray_raw", 32'(temp_raw), 32'd0);
    check("stray_busy", 32'(busy), 32'd0);

    // Sample table
    foreach (vecs[i]) begin
      wait_stat(1'b1, 8'd2, 300, w);
      eng_read(vecs[i]);
      drain("table_drain");
    end
    check("err_after_table", 32'(err_cnt), 32'd0);

    // Read timeout: strobe falls into RD_WAIT, 50 cycles later back to IDLE
    wait_stat(1'b1, 8'd2, 300, w);
    wait_idle(80, k);
    check("rd_timeout_cycles", 32'(k), 32'd50);
    check("rd_timeout_err", 32'(err_cnt), 32'd1);
    wait_stat(1'b1, 8'd2, 300, w);
    eng_read(mk(16'h0000, 12'h000, 12'hF9C, 1'b0)); // (0+1-1-400)/4=-100
    drain("post_tmo_drain");

    // Saturation: 300 more timeouts
    for (int i = 0; i < 300; i++) begin
      wait_stat(1'b1, 8'd2, 300, w);
      wait_idle(80, k);
    end
    check("err_saturated", 32'(err_cnt), 32'hFF);

    // poll_en low: three poll periods with no strobe
    @(posedge clk); #1 poll_en = 1'b0;
    seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (i2c_stat) seen++;
    end
    check("poll_off_stat_cycles", 32'(seen), 32'd0);
    check("poll_off_err", 32'(err_cnt), 32'hFF);
    @(posedge clk); #1 poll_en = 1'b1;

    // Reset in the middle of a read
    wait_stat(1'b1, 8'd2, 300, w);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    wait_stat(1'b0, 8'd4, 40, w);
    check("midrst_pwrup_latency", 32'(w), 32'd10);
    // Configuration ignored once: timeout, then retried
    wait_idle(80, k);
    check("cfg_timeout_cycles", 32'(k), 32'd50);
    check("cfg_timeout_err", 32'(err_cnt), 32'd1);
    wait_stat(1'b0, 8'd4, 10, w);
    eng_wend();
    wait_stat(1'b1, 8'd2, 300, w);
    eng_read(mk(16'h1900, 12'h190, 12'h190, 1'b0)); // history cleared by reset
    drain("final_drain");
    check("final_err", 32'(err_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tmp100_poll_ctrl.md
TMP100_POLL_CTRL -- requirements
Module: tmp100_poll_ctrl

Interface
REQ-001 Parameter POLL_DIV, default 32'd400000, gives the clock cycles between read starts (1 s at 400 kHz).
REQ-002 Parameter PWRUP_DLY, default 16'd1000, gives the cycles waited after reset before the configuration write.
REQ-003 Parameter TMO_CYC, default 16'd2000, gives the maximum cycles allowed for one I2C transaction.
REQ-004 Parameter T_HI, default 12'sd1120 (70.0 C), is the over-temperature set threshold.
REQ-005 Parameter T_LO, default 12'sd1040 (65.0 C), is the over-temperature clear threshold.
REQ-006 Port i2c_clk_in, input, 1, is the single clock, the same clock that drives the downstream I2C engine.
REQ-007 Port i2c_rst_in, input, 1, is an asynchronous active-high reset.
REQ-008 Port poll_en, input, 1, enables periodic reads while high.
REQ-009 Ports i2c_wr_rd, output, 1 (1 = read), and group_number, output, 8, select the engine operation.
REQ-010 Port i2c_stat, output, 1, is the engine start strobe.
REQ-011 Port i2c_wend, input, 1, is the engine end-of-transaction pulse.
REQ-012 Ports i2c_reg_out, input, 16, and i2c_rd_valid, input, 1, carry the engine read data and its valid pulse.
REQ-013 Port temp_raw, output, 12, is the signed last sample at 0.0625 C/LSB.
REQ-014 Port temp_avg, output, 12, is the signed mean of the last 4 samples.
REQ-015 Port temp_valid, output, 1, pulses for one cycle when new samples are available.
REQ-016 Port over_temp, output, 1, is the hysteretic over-temperature alarm.
REQ-017 Port busy, output, 1, is high while a transaction is outstanding.
REQ-018 Port err_cnt, output, 8, counts timeouts and saturates at 8'hFF.

Function
REQ-019 The FSM SHALL have the states PWRUP, CFG_GO, CFG_WAIT, IDLE, RD_GO, RD_WAIT.
- PWRUP: count PWRUP_DLY cycles -> CFG_GO.
REQ-020 CFG_GO SHALL drive i2c_wr_rd=0 and group_number=8'd4, then go to CFG_WAIT.
- This writes the configuration (pointer 01, data 60h = 12-bit resolution), then resets the pointer to 00.
REQ-021 RD_GO SHALL drive i2c_wr_rd=1 and group_number=8'd2, then go to RD_WAIT.
REQ-022 In both GO states, i2c_stat SHALL be high for exactly 4 consecutive cycles.
- The engine samples i2c_stat at half rate.
- i2c_wr_rd and group_number SHALL be stable from the first i2c_stat cycle until the wait state exits.
REQ-023 CFG_WAIT SHALL exit to IDLE on i2c_wend.
REQ-024 RD_WAIT SHALL exit to IDLE on i2c_rd_valid and SHALL ignore i2c_wend.
REQ-025 Any wait state reaching TMO_CYC cycles SHALL increment err_cnt (saturating) and go to IDLE.
- A configuration timeout SHALL return via IDLE to CFG_GO; the configuration write is retried until it succeeds.
REQ-026 IDLE SHALL enter RD_GO when the poll counter reaches POLL_DIV-1 and poll_en=1.
- The poll counter free-runs from the end of the configuration write and wraps to 0.
- With poll_en=0 the poll counter wraps but no read starts.
REQ-027 On i2c_rd_valid in RD_WAIT, temp_raw SHALL be loaded with i2c_reg_out[15:4] on the next edge.
REQ-028 The 4-entry history SHALL shift on the same edge as REQ-027.
- temp_avg = arithmetic right shift by 2 of the 14-bit signed sum (rounding toward minus infinity).
- Before 4 samples exist, unfilled entries repeat the first sample.
REQ-029 temp_valid SHALL pulse one cycle after temp_raw and temp_avg update, giving a 2-cycle latency from i2c_rd_valid.
REQ-030 over_temp SHALL set when temp_avg >= T_HI and clear when temp_avg <= T_LO, using signed compares; between the thresholds it holds.
REQ-031 busy SHALL be high in every state except IDLE and PWRUP.
REQ-032 i2c_rd_valid or i2c_wend arriving outside a wait state SHALL be ignored.

Reset
REQ-033 On i2c_rst_in=1, asynchronously:
- state=PWRUP;
- i2c_stat=0, i2c_wr_rd=0, group_number=0;
- temp_raw=0, temp_avg=0, temp_valid=0, over_temp=0, busy=0, err_cnt=0;
- history cleared, all counters 0.
REQ-034 Reset asserted mid-transaction SHALL abandon it; the configuration write SHALL be repeated after PWRUP_DLY.

Structure
REQ-035 Package tmp100_pkg SHALL hold:
- the state enumeration;
- the TMP100 constants: the pointer values, CFG_DATA=8'h60, and the group numbers 4 and 2;
- the 0.0625 C LSB scale comment constant.
REQ-036 Sub-module tmp100_avg4 SHALL contain the history registers, the summation and the hysteresis compare.
REQ-037 The top SHALL contain the FSM, the timers and err_cnt.

Verification (small parameters: POLL_DIV=100, PWRUP_DLY=10, TMO_CYC=50)
REQ-038 Release reset -> after 10 cycles, i2c_stat is high for 4 cycles with wr_rd=0 and group=4; busy=1.
REQ-039 Model the engine: i2c_wend, then i2c_rd_valid with reg_out=16'h1900 (25.0 C) -> temp_raw=12'h190, temp_avg=12'h190, and temp_valid pulses exactly 2 cycles after i2c_rd_valid.
REQ-040 Samples 12'h190, 12'h190, 12'h4B0, 12'h4B0 (75 C) -> temp_avg=12'h320 and over_temp=0.
- Two more samples of 12'h4B0 -> temp_avg=12'h4B0 and over_temp=1.
- Samples of 12'h3E8 (62.5 C) until temp_avg <= 1040 -> over_temp=0.
REQ-041 Negative sample reg_out=16'hE700 (-25 C) -> temp_raw=12'hE70 and temp_avg is sign-correct.
REQ-042 Engine silent in RD_WAIT -> after 50 cycles, err_cnt=1, the FSM returns to IDLE, and the next poll starts normally.
- 300 forced timeouts -> err_cnt holds 8'hFF.
REQ-043 poll_en=0 -> no i2c_stat for 3 poll periods.
- Reset pulsed during RD_WAIT -> all outputs return to reset values and a configuration write follows.
